// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge-event arbiter: FSM state, channel limit, wrap increment.
// Pure declarations, no logic of its own.
package edge_evt_pkg;

  typedef enum logic {IDLE, OFFER} arb_state_e;

  localparam int MAX_CH = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/edge_evt_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above start, wrapping.
// Zero latency; no flow control.
module edge_evt_rr_pick #(
  parameter  int W  = 4,
  localparam int PW = $clog2(W)
) (
  input  logic [W-1:0]  req,
  input  logic [PW-1:0] start,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [PW:0] pos;

  // Walk offsets from the far end so the nearest set bit to start is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = W - 1; k >= 0; k--) begin
      pos = {1'b0, start} + (PW+1)'(k);
      if (pos >= (PW+1)'(W)) pos = pos - (PW+1)'(W);
      if (req[pos[PW-1:0]]) begin
        found = 1'b1;
        idx   = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event scheduler: sticky per-channel events served round-robin over valid/ready, one accept per cycle.
// Edge to pending 1 cycle, pending to valid 1 more; valid held until ready. FALLING_EDGE_EN adds falling events.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] din,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_pol,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overflow
);

`ifdef FALLING_EDGE_EN
  localparam int NE = 2 * NUM_CH;
`else
  localparam int NE = NUM_CH;
`endif
  localparam int EW = $clog2(NE);

  logic [NUM_CH-1:0] din_q, rise;
  logic [NE-1:0]     ev_set, ev_en, ev_clr, ev_pend, ev_ovf, ev_acc, req;
  logic [EW-1:0]     evt_idx, rr_ptr, start, pick_idx, idx_next;
  logic              pick_found, pick_pol, accept;
  arb_state_e        state;

  assign rise = din & ~din_q & ch_en;

`ifdef FALLING_EDGE_EN
  logic [NUM_CH-1:0] fall;
  assign fall = ~din & din_q & ch_en;

  // Event slot 2*i is the rising edge of channel i, slot 2*i+1 its falling edge.
  always_comb begin
    ev_set   = '0;
    ev_en    = '0;
    ev_clr   = '0;
    pending  = '0;
    overflow = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ev_set[2*i]   = rise[i];
      ev_set[2*i+1] = fall[i];
      ev_en[2*i]    = ch_en[i];
      ev_en[2*i+1]  = ch_en[i];
      ev_clr[2*i]   = ovf_clr[i];
      ev_clr[2*i+1] = ovf_clr[i];
      pending[i]    = ev_pend[2*i] | ev_pend[2*i+1];
      overflow[i]   = ev_ovf[2*i] | ev_ovf[2*i+1];
    end
  end
  assign evt_ch   = evt_idx[EW-1:1];
  assign pick_pol = ~pick_idx[0];
`else
  assign ev_set   = rise;
  assign ev_en    = ch_en;
  assign ev_clr   = ovf_clr;
  assign pending  = ev_pend;
  assign overflow = ev_ovf;
  assign evt_ch   = evt_idx;
  assign pick_pol = 1'b1;
`endif

  assign accept   = evt_valid & evt_ready;
  assign ev_acc   = accept ? (NE'(1) << evt_idx) : '0;
  assign req      = ev_pend & ev_en & ~ev_acc;
  assign idx_next = EW'(rr_next(int'(evt_idx), NE));
  assign start    = accept ? idx_next : rr_ptr;

  edge_evt_rr_pick #(.W(NE)) u_pick (
    .req   (req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din_q     <= '0;
      ev_pend   <= '0;
      ev_ovf    <= '0;
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_pol   <= 1'b0;
      rr_ptr    <= '0;
      state     <= IDLE;
    end else begin
      din_q   <= din;
      // A new edge beats a same-cycle accept or clear.
      ev_pend <= (ev_pend & ~ev_acc & ev_en) | ev_set;
      ev_ovf  <= (ev_ovf & ~ev_clr) | (ev_set & ev_pend & ~ev_acc);
      case (state)
        IDLE: begin
          if (pick_found) begin
            evt_idx   <= pick_idx;
            evt_pol   <= pick_pol;
            evt_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (accept) begin
            rr_ptr <= idx_next;
            if (pick_found) begin
              evt_idx <= pick_idx;
              evt_pol <= pick_pol;
            end else begin
              evt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter (default build): expected grants are queued as edges are driven
// and checked against every accepted handshake; scenario tasks add inline cycle-level checks.
module tb_edge_event_arbiter;

  localparam int NUM_CH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] ch_en = '0;
  logic [3:0] ovf_clr = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_pol;
  logic [3:0] pending;
  logic [3:0] overflow;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int mon_exp;

  always #5 clk = ~clk;

  edge_event_arbiter #(.NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .ch_en     (ch_en),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_pol   (evt_pol),
    .pending   (pending),
    .overflow  (overflow)
  );

  // Inputs change only at posedge+1, so values seen here are the ones the next edge uses.
  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got ch=%0d, required no event", evt_ch);
      end else begin
        mon_exp = exp_q.pop_front();
        if (int'(evt_ch) !== mon_exp) begin
          errors++;
          $display("FAIL grant_order: got ch=%0d, required ch=%0d", evt_ch, mon_exp);
        end
      end
      checks++;
      if (evt_pol !== 1'b1) begin
        errors++;
        $display("FAIL evt_pol: got %b, required 1", evt_pol);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    din = '0; ch_en = '0; ovf_clr = '0; evt_ready = 1'b0;
    exp_q.delete();
    repeat (2) cyc();
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) cyc();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", evt_valid); end
    checks++; if (evt_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d, required 0", evt_ch); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %b, required 0000", pending); end
    checks++; if (overflow !== 4'h0) begin errors++; $display("FAIL reset_overflow: got %b, required 0000", overflow); end
    resetn = 1'b1;
    din = 4'hF;
    cyc();
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL disabled_rise: got pending=%b, required 0000", pending); end
    din = 4'h0;
    repeat (2) cyc();
  endtask

  task automatic test_single();
    ch_en = 4'hF; evt_ready = 1'b1;
    din = 4'b0100; exp_q.push_back(2);
    cyc();
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b, required 0100", pending); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b, required 0", evt_valid); end
    cyc();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd2) begin errors++; $display("FAIL single_offer: got valid=%b ch=%0d, required valid=1 ch=2", evt_valid, evt_ch); end
    cyc();
    checks++; if (pending !== 4'h0 || evt_valid !== 1'b0) begin errors++; $display("FAIL single_after_accept: got pending=%b valid=%b, required 0000/0", pending, evt_valid); end
    din = 4'h0;
    wait_drain("single");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch [3];
    exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd3;
    do_reset();
    ch_en = 4'hF; evt_ready = 1'b1;
    din = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    cyc();
    checks++; if (pending !== 4'b1011) begin errors++; $display("FAIL rr_pending: got %b, required 1011", pending); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== exp_ch[i]) begin
        errors++;
        $display("FAIL rr_b2b_%0d: got valid=%b ch=%0d, required valid=1 ch=%0d", i, evt_valid, evt_ch, exp_ch[i]);
      end
    end
    cyc();
    checks++; if (evt_valid !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL rr_idle: got valid=%b pending=%b, required 0/0000", evt_valid, pending); end
    din = 4'h0;
    cyc();
    // Pointer must be back at 0: channel 0 beats channel 3.
    din = 4'b1001; exp_q.push_back(0); exp_q.push_back(3);
    wait_drain("rr_ptr_wrap");
    din = 4'h0;
    cyc();
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    din = 4'b0010; exp_q.push_back(1);
    repeat (2) cyc();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin errors++; $display("FAIL ovf_offer: got valid=%b ch=%0d, required valid=1 ch=1", evt_valid, evt_ch); end
    din = 4'b0000; cyc();
    din = 4'b0010; cyc();
    checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_set: got %b, required 0010", overflow); end
    din = 4'b0000; ovf_clr = 4'b0010; cyc(); ovf_clr = 4'h0;
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b, required 0000", overflow); end
    din = 4'b0010; ovf_clr = 4'b0010; cyc(); ovf_clr = 4'h0; din = 4'b0000;
    checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_set_beats_clear: got %b, required 0010", overflow); end
    ovf_clr = 4'b0010; cyc(); ovf_clr = 4'h0;
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clear2: got %b, required 0000", overflow); end
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin errors++; $display("FAIL ovf_held: got valid=%b ch=%0d, required valid=1 ch=1", evt_valid, evt_ch); end
    evt_ready = 1'b1;
    wait_drain("overflow");
    checks++; if (pending !== 4'h0 || evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_single_event: got pending=%b valid=%b, required 0000/0", pending, evt_valid); end
  endtask

  task automatic test_same_cycle();
    evt_ready = 1'b1;
    din = 4'b0001; exp_q.push_back(0);
    cyc();
    din = 4'b0000;
    cyc();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin errors++; $display("FAIL same_offer: got valid=%b ch=%0d, required valid=1 ch=0", evt_valid, evt_ch); end
    din = 4'b0001; exp_q.push_back(0);
    cyc();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL same_set_wins: got pending=%b, required 0001", pending); end
    checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL same_no_ovf: got overflow=%b, required 0000", overflow); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL same_drop: got valid=%b, required 0", evt_valid); end
    cyc();
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin errors++; $display("FAIL same_reoffer: got valid=%b ch=%0d, required valid=1 ch=0", evt_valid, evt_ch); end
    din = 4'b0000;
    wait_drain("same_cycle");
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL same_final: got pending=%b, required 0000", pending); end
  endtask

  task automatic test_disable();
    evt_ready = 1'b0;
    din = 4'b0001; exp_q.push_back(0);
    repeat (2) cyc();
    din = 4'b1001;
    cyc();
    checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL dis_pending: got %b, required 1001", pending); end
    ch_en = 4'b0111;
    cyc();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL dis_clear: got %b, required 0001", pending); end
    checks++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin errors++; $display("FAIL dis_offer_held: got valid=%b ch=%0d, required valid=1 ch=0", evt_valid, evt_ch); end
    evt_ready = 1'b1;
    wait_drain("disable");
    repeat (4) cyc();
    checks++; if (pending !== 4'h0 || evt_valid !== 1'b0) begin errors++; $display("FAIL dis_final: got pending=%b valid=%b, required 0000/0", pending, evt_valid); end
    din = 4'h0; cyc();
    ch_en = 4'hF; cyc();
  endtask

  task automatic test_async_reset();
    evt_ready = 1'b0;
    din = 4'b0110;
    repeat (2) cyc();
    din = 4'b0010; cyc();
    din = 4'b0110; cyc();
    checks++; if (overflow !== 4'b0100 || evt_valid !== 1'b1) begin errors++; $display("FAIL ar_pre: got overflow=%b valid=%b, required 0100/1", overflow, evt_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b, required 0 before any edge", evt_valid); end
    checks++; if (pending !== 4'h0 || overflow !== 4'h0) begin errors++; $display("FAIL ar_state: got pending=%b overflow=%b, required 0000/0000", pending, overflow); end
    repeat (2) cyc();
    resetn = 1'b1;
    evt_ready = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2);
    wait_drain("async_reset");
    repeat (6) cyc();
    checks++; if (pending !== 4'h0 || evt_valid !== 1'b0) begin errors++; $display("FAIL ar_once: got pending=%b valid=%b, required 0000/0", pending, evt_valid); end
    din = 4'h0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_same_cycle();
    test_disable();
    test_async_reset();
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
